// File: rtl/usb_in_stream_arbiter_pkg.sv
// Shared types and constants for the USB CDC IN stream arbiter.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        STREAM
    } arb_state_e;

    localparam logic [3:0]  HDR_TAG = 4'hA;
    localparam int unsigned MAX_REQ = 16;

endpackage

// File: rtl/usb_in_stream_arbiter_if.sv
// Requester-side and CDC-side byte handshakes of the IN stream arbiter.
interface usb_in_stream_arbiter_if #(
    parameter int unsigned N_REQ = 3
);
    logic [8*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]   req_valid_i;
    logic [N_REQ-1:0]   req_last_i;
    logic [N_REQ-1:0]   req_ready_o;
    logic [7:0]         out_data_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [N_REQ-1:0]   grant_o;
    logic               busy_o;

    modport master (
        input  req_data_i, req_valid_i, req_last_i, out_ready_i,
        output req_ready_o, out_data_o, out_valid_o, grant_o, busy_o
    );

    modport slave (
        output req_data_i, req_valid_i, req_last_i, out_ready_i,
        input  req_ready_o, out_data_o, out_valid_o, grant_o, busy_o
    );
endinterface

// File: rtl/usb_in_stream_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping at N.
module usb_rr_pick #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   ptr_i,
    output logic [3:0]   idx_o,
    output logic         any_o
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [3:0]     start;
    logic [3:0]     pos;
    logic [4:0]     sum;
    logic           found;

    always_comb begin
        if (32'(ptr_i) + 32'd1 >= N) start = '0;
        else                         start = ptr_i + 4'd1;
        // Rotate so the search origin sits at bit 0, then priority-encode.
        dbl   = {req_i, req_i} >> start;
        rot   = dbl[N-1:0];
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (rot[i] && !found) begin
                pos   = 4'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, pos} + {1'b0, start};
        if (32'(sum) >= N) idx_o = 4'(32'(sum) - N);
        else               idx_o = sum[3:0];
        any_o = |req_i;
    end
endmodule

// File: rtl/usb_in_stream_arbiter.sv
// Round-robin, burst-granular arbiter sharing one CDC IN byte channel between
// N_REQ byte-stream requesters, with an optional source-id header per burst.
module usb_in_stream_arbiter
    import usb_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned HEADER_EN    = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    usb_in_stream_arbiter_if.master bus
);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]        pick_idx;
    logic              pick_any;
    logic              sel_valid, sel_last;
    logic [7:0]        sel_data;
    logic              xfer;

    usb_rr_pick #(.N(N_REQ)) u_pick (
        .req_i (bus.req_valid_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_q == 4'(k)) begin
                sel_valid = bus.req_valid_i[k];
                sel_last  = bus.req_last_i[k];
                sel_data  = bus.req_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        ptr_d           = ptr_q;
        byte_cnt_d      = byte_cnt_q;
        idle_cnt_d      = idle_cnt_q;
        xfer            = 1'b0;
        bus.req_ready_o = '0;
        bus.out_data_o  = '0;
        bus.out_valid_o = 1'b0;
        bus.grant_o     = '0;
        bus.busy_o      = 1'b0;

        // Outputs are held at zero for the whole reset cycle.
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    if (pick_any) begin
                        gnt_d   = pick_idx;
                        ptr_d   = pick_idx;
                        state_d = (HEADER_EN != 0) ? HEADER : STREAM;
                    end
                end
                HEADER: begin
                    bus.busy_o      = 1'b1;
                    bus.out_valid_o = 1'b1;
                    bus.out_data_o  = {HDR_TAG, gnt_q};
                    for (int unsigned k = 0; k < N_REQ; k++) bus.grant_o[k] = (gnt_q == 4'(k));
                    if (bus.out_ready_i) state_d = STREAM;
                end
                STREAM: begin
                    bus.busy_o      = 1'b1;
                    bus.out_valid_o = sel_valid;
                    bus.out_data_o  = sel_data;
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        bus.grant_o[k]     = (gnt_q == 4'(k));
                        bus.req_ready_o[k] = (gnt_q == 4'(k)) && bus.out_ready_i;
                    end
                    xfer = sel_valid && bus.out_ready_i;
                    if (sel_valid) begin
                        // A stalled-but-valid requester is not idle.
                        idle_cnt_d = '0;
                        if (xfer) begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            if (sel_last || byte_cnt_q == 8'(MAX_BURST - 1)) begin
                                state_d    = IDLE;
                                byte_cnt_d = '0;
                            end
                        end
                    end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= 4'(N_REQ - 1);
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
endmodule

// File: tb/tb_usb_in_stream_arbiter.sv
// Directed bench for usb_in_stream_arbiter with a cycle-level reference model
// and hand-computed checks on the captured output stream.
module tb_usb_in_stream_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned MB = 64;
    localparam int unsigned IT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_in_stream_arbiter_if #(.N_REQ(N)) bus ();

    usb_in_stream_arbiter #(
        .N_REQ        (N),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IT),
        .HEADER_EN    (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q_data [N][$];
    bit         q_last [N][$];
    bit [N-1:0] src_en = '1;
    bit         ord    = 1'b1;

    logic [7:0]   xlog[$];
    logic [N-1:0] h_grant[$];
    logic [N-1:0] h_rdy[$];
    logic         h_busy[$];
    logic         h_ovalid[$];
    logic [7:0]   h_odata[$];

    // Model: current owner (-1 when nobody holds the channel) and burst progress.
    int m_owner = -1;
    int m_prev  = int'(N) - 1;
    int m_sent  = 0;
    int m_quiet = 0;
    bit m_hdr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input bit l);
        q_data[k].push_back(d);
        q_last[k].push_back(l);
    endtask

    task automatic drive();
        for (int k = 0; k < int'(N); k++) begin
            if (src_en[k] && q_data[k].size() > 0) begin
                bus.req_valid_i[k]       = 1'b1;
                bus.req_data_i[8*k +: 8] = q_data[k][0];
                bus.req_last_i[k]        = q_last[k][0];
            end else begin
                bus.req_valid_i[k]       = 1'b0;
                bus.req_data_i[8*k +: 8] = 8'h00;
                bus.req_last_i[k]        = 1'b0;
            end
        end
        bus.out_ready_i = ord;
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1;
            m_prev  = int'(N) - 1;
            m_sent  = 0;
            m_quiet = 0;
            m_hdr   = 1'b0;
        end else if (m_owner < 0) begin
            for (int s = 1; s <= int'(N); s++) begin
                int c;
                c = (m_prev + s) % int'(N);
                if (bus.req_valid_i[c]) begin
                    m_owner = c;
                    m_prev  = c;
                    m_hdr   = 1'b1;
                    m_sent  = 0;
                    m_quiet = 0;
                    break;
                end
            end
        end else if (m_hdr) begin
            if (bus.out_ready_i) m_hdr = 1'b0;
        end else if (bus.req_valid_i[m_owner]) begin
            m_quiet = 0;
            if (bus.out_ready_i) begin
                m_sent++;
                if (bus.req_last_i[m_owner] || m_sent == int'(MB)) m_owner = -1;
            end
        end else begin
            m_quiet++;
            if (m_quiet == int'(IT)) m_owner = -1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] e_grant, e_rdy, fired;
        logic         e_busy, e_valid;
        logic [7:0]   e_data;
        @(negedge clk);
        e_grant = '0;
        e_rdy   = '0;
        e_busy  = 1'b0;
        e_valid = 1'b0;
        e_data  = 8'h00;
        if (!rst && m_owner >= 0) begin
            e_grant = N'(1 << m_owner);
            e_busy  = 1'b1;
            if (m_hdr) begin
                e_valid = 1'b1;
                e_data  = 8'hA0 | 8'(m_owner);
            end else begin
                e_valid = bus.req_valid_i[m_owner];
                e_data  = bus.req_data_i[8*m_owner +: 8];
                e_rdy   = bus.out_ready_i ? e_grant : '0;
            end
        end
        chk("grant_o", 32'(bus.grant_o), 32'(e_grant));
        chk("busy_o", 32'(bus.busy_o), 32'(e_busy));
        chk("out_valid_o", 32'(bus.out_valid_o), 32'(e_valid));
        chk("out_data_o", 32'(bus.out_data_o), 32'(e_data));
        chk("req_ready_o", 32'(bus.req_ready_o), 32'(e_rdy));
        h_grant.push_back(bus.grant_o);
        h_rdy.push_back(bus.req_ready_o);
        h_busy.push_back(bus.busy_o);
        h_ovalid.push_back(bus.out_valid_o);
        h_odata.push_back(bus.out_data_o);
        if (bus.out_valid_o && bus.out_ready_i) xlog.push_back(bus.out_data_o);
        fired = bus.req_valid_i & bus.req_ready_o;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < int'(N); k++) begin
            if (fired[k] && q_data[k].size() > 0) begin
                void'(q_data[k].pop_front());
                void'(q_last[k].pop_front());
            end
        end
        drive();
    endtask

    task automatic clear_logs();
        xlog.delete();
        h_grant.delete();
        h_rdy.delete();
        h_busy.delete();
        h_ovalid.delete();
        h_odata.delete();
    endtask

    task automatic do_reset();
        for (int k = 0; k < int'(N); k++) begin
            q_data[k].delete();
            q_last[k].delete();
        end
        src_en = '1;
        ord    = 1'b1;
        rst    = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        drive();
        clear_logs();
    endtask

    initial begin
        logic [7:0] exp2 [18];
        int         cnt;

        drive();
        tick();
        do_reset();
        chk("reset_grant", 32'(bus.grant_o), 32'h0);
        chk("reset_ptr_order_busy", 32'(bus.busy_o), 32'h0);

        // Single 3-byte message from requester 0.
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        drive();
        repeat (8) tick();
        chk("t1_len", 32'(xlog.size()), 32'd4);
        chk("t1_b0", 32'(xlog[0]), 32'hA0);
        chk("t1_b1", 32'(xlog[1]), 32'h11);
        chk("t1_b3", 32'(xlog[3]), 32'h33);
        chk("t1_grant_c0", 32'(h_grant[0]), 32'h0);
        chk("t1_grant_c1", 32'(h_grant[1]), 32'h1);
        chk("t1_busy_c4", 32'(h_busy[4]), 32'h1);
        chk("t1_busy_c5", 32'(h_busy[5]), 32'h0);

        // Requesters 0 and 2 contend with 2-byte messages.
        do_reset();
        for (int m = 0; m < 3; m++) begin
            push(0, 8'(8'h01 + 2*m), 0); push(0, 8'(8'h02 + 2*m), 1);
            push(2, 8'(8'h21 + 2*m), 0); push(2, 8'(8'h22 + 2*m), 1);
        end
        drive();
        repeat (30) tick();
        exp2 = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22,
                 8'hA0, 8'h03, 8'h04, 8'hA2, 8'h23, 8'h24,
                 8'hA0, 8'h05, 8'h06, 8'hA2, 8'h25, 8'h26};
        chk("t2_len", 32'(xlog.size()), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (i < xlog.size()) chk("t2_stream", 32'(xlog[i]), 32'(exp2[i]));
        end

        // Requester 1 streams 70 bytes without last: burst split at 64.
        clear_logs();
        for (int i = 0; i < 70; i++) push(1, 8'(i), 0);
        drive();
        repeat (100) tick();
        chk("t3_len", 32'(xlog.size()), 32'd72);
        chk("t3_hdr0", 32'(xlog[0]), 32'hA1);
        chk("t3_b63", 32'(xlog[64]), 32'd63);
        chk("t3_hdr1", 32'(xlog[65]), 32'hA1);
        chk("t3_b64", 32'(xlog[66]), 32'd64);
        chk("t3_b69", 32'(xlog[71]), 32'd69);
        cnt = 0;
        for (int c = 2; c <= 73; c++) if (!h_rdy[c][1]) cnt++;
        chk("t3_ready_gaps", 32'(cnt), 32'd2);
        chk("t3_idle_c66", 32'(h_busy[66]), 32'h0);
        chk("t3_grant_c67", 32'(h_grant[67]), 32'h2);

        // Requester 0 goes quiet after 2 bytes; timeout hands over to 2.
        do_reset();
        push(0, 8'h31, 0); push(0, 8'h32, 0); push(2, 8'h41, 1);
        drive();
        repeat (26) tick();
        chk("t4_grant_c19", 32'(h_grant[19]), 32'h1);
        chk("t4_grant_c20", 32'(h_grant[20]), 32'h0);
        chk("t4_grant_c21", 32'(h_grant[21]), 32'h4);
        chk("t4_hdr2", 32'(xlog[3]), 32'hA2);
        chk("t4_b41", 32'(xlog[4]), 32'h41);

        // Long downstream stall while valid: no timeout.
        do_reset();
        push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1);
        drive();
        repeat (3) tick();
        ord = 1'b0;
        drive();
        repeat (40) tick();
        ord = 1'b1;
        drive();
        repeat (6) tick();
        cnt = 0;
        for (int c = 3; c <= 42; c++) if (h_grant[c] == 3'b001) cnt++;
        chk("t4b_held", 32'(cnt), 32'd40);
        chk("t4b_len", 32'(xlog.size()), 32'd4);
        chk("t4b_b53", 32'(xlog[3]), 32'h53);
        chk("t4b_busy_c45", 32'(h_busy[45]), 32'h0);

        // Header stalled 10 cycles while requester 0 withdraws valid.
        do_reset();
        ord = 1'b0;
        push(0, 8'h61, 0);
        drive();
        tick();
        src_en[0] = 1'b0;
        drive();
        repeat (10) tick();
        ord = 1'b1;
        drive();
        repeat (20) tick();
        cnt = 0;
        for (int c = 1; c <= 10; c++) if (h_ovalid[c] && h_odata[c] == 8'hA0) cnt++;
        chk("t5_hdr_held", 32'(cnt), 32'd10);
        chk("t5_len", 32'(xlog.size()), 32'd1);
        chk("t5_grant_c27", 32'(h_grant[27]), 32'h1);
        chk("t5_grant_c28", 32'(h_grant[28]), 32'h0);

        // Reset mid-burst on byte 5 of requester 1.
        do_reset();
        for (int i = 0; i < 10; i++) push(1, 8'(8'h50 + i), (i == 9));
        drive();
        repeat (6) tick();
        rst = 1'b1;
        push(0, 8'h71, 1);
        drive();
        tick();
        rst = 1'b0;
        drive();
        repeat (4) tick();
        chk("t6_rst_valid", 32'(h_ovalid[6]), 32'h0);
        chk("t6_grant_c7", 32'(h_grant[7]), 32'h0);
        chk("t6_busy_c7", 32'(h_busy[7]), 32'h0);
        chk("t6_rdy_c7", 32'(h_rdy[7]), 32'h0);
        chk("t6_grant_c8", 32'(h_grant[8]), 32'h1);
        chk("t6_b53", 32'(xlog[4]), 32'h53);
        chk("t6_hdr0", 32'(xlog[5]), 32'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
